danger_scheduler: RTL and testbench
===================================

DANGER_SCHEDULER -- requirements
Module: danger_scheduler

Interface
REQ-001 Parameter SPAWN_POS, default 700, right-edge x of a newly spawned obstacle; off-screen right.
REQ-002 Parameter MIN_GAP, default 160, minimum scrolled pixels between two spawns.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; must be non-zero.
REQ-004 Port clk, input, 1, system clock; the only clock.
REQ-005 Port rst, input, 1, reset; synchronous, active-low.
REQ-006 Port frame_tick, input, 1, one-cycle pulse once per video frame.
REQ-007 Port game_state, input, 2, INIT=0, START=1, END=2, RESET=3.
REQ-008 Port speed, input, 4, scroll pixels per frame.
REQ-009 Ports danger_pos1..3, output, 10 each, right-edge x of slot n.
REQ-010 Ports danger_type1..3, output, 3 each, obstacle type of slot n; codes: LOW_BIRD=0, HIGH_BIRD=1, SMALL_CACTUS=2, MANY_CACTUS=3, BIG_CACTUS=4, NOTHING=5.
REQ-011 Ports danger_en1..3, output, 1 each, slot n active.

Function
REQ-012 All outputs SHALL be registered, with one-cycle latency from the sampled frame_tick.
REQ-013 The FSM SHALL have states IDLE, RUN, FROZEN, selected every cycle as INIT→IDLE, START→RUN, END→FROZEN, RESET→IDLE with clear.
REQ-014 In IDLE, frame_tick SHALL be ignored and all slots and counters held.
REQ-015 On entry to IDLE via RESET, all slots SHALL be cleared (en=0, pos=0, type=NOTHING), dist=0 and gap=MIN_GAP, on the next edge.
REQ-016 In FROZEN, all outputs and counters SHALL hold and frame_tick SHALL be ignored.
REQ-017 In RUN on frame_tick, each enabled slot SHALL move: if pos > speed then pos ← pos − speed, else en ← 0, pos ← 0, type ← NOTHING (no underflow).
REQ-018 In RUN on frame_tick, dist ← min(dist + speed, 1023), a 10-bit saturating counter.
REQ-019 The spawn check SHALL use post-move slot vacancy and the updated dist, so a slot freed this tick is reusable in the same tick.
REQ-020 Spawn SHALL occur when dist ≥ gap and at least one slot is free.
REQ-021 Spawn SHALL use the lowest-index free slot: en ← 1, pos ← SPAWN_POS, type ← map(lfsr[2:0]).
REQ-022 On spawn, dist ← 0 and gap ← MIN_GAP + lfsr[10:4], giving a range of MIN_GAP..MIN_GAP+127.
REQ-023 At most one spawn SHALL occur per frame_tick.
REQ-024 If dist ≥ gap but no slot is free, no spawn SHALL occur and dist SHALL keep saturating.
REQ-025 Type map: values 0–4 pass through; 5→SMALL_CACTUS, 6→BIG_CACTUS, 7→MANY_CACTUS. Type NOTHING SHALL never be spawned.
REQ-026 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk cycle in all states, including IDLE and FROZEN.
REQ-027 speed=0 SHALL cause no movement and no dist change; a spawn is still allowed if dist ≥ gap already.
REQ-028 A game_state change in the same cycle as frame_tick SHALL be resolved by the new state; a tick coinciding with END is ignored.
REQ-029 A type change for an enabled slot SHALL occur only at spawn or free.

Reset
REQ-030 While rst=0 at clk edge: all en=0, pos=0, type=NOTHING, dist=0, gap=MIN_GAP, lfsr=LFSR_SEED, FSM=IDLE.
REQ-031 Reset asserted mid-RUN SHALL override all pending movement and spawn on that edge.
REQ-032 The first RUN tick after release SHALL behave as in REQ-017 to REQ-025.

Structure
REQ-033 The shared package SHALL hold the game_state codes, the danger type codes, the FSM state enum, and the SPAWN_POS and MIN_GAP defaults.
REQ-034 The LFSR SHALL be one sub-module, danger_lfsr (seed parameter, enable input, 16-bit state output).
REQ-035 Slot logic SHALL be replicated per slot; there SHALL be no other sub-modules.

Verification
REQ-036 Reset, then START, speed=4: 40 ticks → slot1 spawns (dist=160), pos=700, en1=1, type from map; en2=en3=0.
REQ-037 Slot pos=3, speed=4, tick → en=0, pos=0, type=5; same tick with dist≥gap → slot respawns at 700.
REQ-038 Three slots active, dist=1023 → no spawn; next free slot → immediate spawn on that tick, dist→0.
REQ-039 RUN, slot1 pos=500, game_state=END with tick → pos holds 500 for 10 ticks; RESET → all en=0 next cycle.
REQ-040 Force lfsr[2:0]=5,6,7 at spawn → types 2,4,3 respectively.
REQ-041 rst=0 asserted mid-RUN with tick in the same cycle → all outputs at reset values, lfsr=16'hACE1.

Source files
------------

// File: rtl/danger_scheduler_pkg.sv
// Shared codes, FSM state encoding and default geometry for the obstacle scheduler.
package danger_scheduler_pkg;

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_START = 2'd1,
        GS_END   = 2'd2,
        GS_RESET = 2'd3
    } game_state_t;

    typedef enum logic [2:0] {
        LOW_BIRD     = 3'd0,
        HIGH_BIRD    = 3'd1,
        SMALL_CACTUS = 3'd2,
        MANY_CACTUS  = 3'd3,
        BIG_CACTUS   = 3'd4,
        NOTHING      = 3'd5
    } danger_type_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } fsm_state_t;

    localparam int SPAWN_POS_DEFAULT = 700;
    localparam int MIN_GAP_DEFAULT   = 160;
    localparam int NUM_SLOTS         = 3;

    // Folds the three spare random codes onto cactus types so NOTHING is never spawned.
    function automatic danger_type_t map_type(input logic [2:0] v);
        case (v)
            3'd5:    map_type = SMALL_CACTUS;
            3'd6:    map_type = BIG_CACTUS;
            3'd7:    map_type = MANY_CACTUS;
            default: map_type = danger_type_t'(v);
        endcase
    endfunction

endpackage

// File: rtl/danger_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; supplies obstacle type and gap randomness.
module danger_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/danger_scheduler.sv
// Three-slot obstacle scheduler: scrolls active obstacles each frame and spawns new
// ones into the lowest free slot once enough distance has scrolled by.
module danger_scheduler
    import danger_scheduler_pkg::*;
#(
    parameter int          SPAWN_POS = SPAWN_POS_DEFAULT,
    parameter int          MIN_GAP   = MIN_GAP_DEFAULT,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] game_state,
    input  logic [3:0] speed,
    output logic [9:0] danger_pos1,
    output logic [9:0] danger_pos2,
    output logic [9:0] danger_pos3,
    output logic [2:0] danger_type1,
    output logic [2:0] danger_type2,
    output logic [2:0] danger_type3,
    output logic       danger_en1,
    output logic       danger_en2,
    output logic       danger_en3
);

    game_state_t gs;
    fsm_state_t  state_q, next_state;
    logic        do_step, do_clear;

    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic [9:0]  dist_q, gap_q, dist_nx;
    logic [10:0] dist_sum;

    logic [NUM_SLOTS-1:0]       slot_en, mv_en, spawn_sel;
    logic [NUM_SLOTS-1:0][9:0]  slot_pos;
    logic [NUM_SLOTS-1:0][2:0]  slot_type;
    logic                       found, spawn;
    danger_type_t               spawn_type;

    assign gs = game_state_t'(game_state);

    danger_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    // Only the type and gap fields of the LFSR are consumed.
    assign lfsr_unused = ^{lfsr[15:11], lfsr[3]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state_q;
        case (gs)
            GS_INIT:  next_state = ST_IDLE;
            GS_START: next_state = ST_RUN;
            GS_END:   next_state = ST_FROZEN;
            GS_RESET: next_state = ST_IDLE;
            default:  next_state = state_q;
        endcase
    end

    // Actions follow the state being entered, so a tick arriving with END is dropped.
    always_comb begin
        do_step  = (next_state == ST_RUN) && frame_tick;
        do_clear = (gs == GS_RESET);
    end

    assign dist_sum   = {1'b0, dist_q} + 11'(speed);
    assign dist_nx    = dist_sum[10] ? 10'h3FF : dist_sum[9:0];
    assign spawn_type = map_type(lfsr[2:0]);

    // Lowest-index slot that is free after this tick's movement.
    always_comb begin
        spawn_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!mv_en[i] && !found) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
        if (dist_nx < gap_q) spawn_sel = '0;
        spawn = |spawn_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst || do_clear) begin
            dist_q <= '0;
            gap_q  <= 10'(MIN_GAP);
        end else if (do_step) begin
            if (spawn) begin
                dist_q <= '0;
                gap_q  <= 10'(MIN_GAP) + {3'b000, lfsr[10:4]};
            end else begin
                dist_q <= dist_nx;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic         en_r, en_nx;
        logic [9:0]   pos_r, pos_nx;
        danger_type_t type_r, type_nx;

        always_comb begin
            en_nx   = en_r;
            pos_nx  = pos_r;
            type_nx = type_r;
            if (en_r) begin
                if (pos_r > 10'(speed)) begin
                    pos_nx = pos_r - 10'(speed);
                end else begin
                    en_nx   = 1'b0;
                    pos_nx  = '0;
                    type_nx = NOTHING;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst || do_clear) begin
                en_r   <= 1'b0;
                pos_r  <= '0;
                type_r <= NOTHING;
            end else if (do_step) begin
                if (spawn_sel[i]) begin
                    en_r   <= 1'b1;
                    pos_r  <= 10'(SPAWN_POS);
                    type_r <= spawn_type;
                end else begin
                    en_r   <= en_nx;
                    pos_r  <= pos_nx;
                    type_r <= type_nx;
                end
            end
        end

        assign mv_en[i]     = en_nx;
        assign slot_en[i]   = en_r;
        assign slot_pos[i]  = pos_r;
        assign slot_type[i] = type_r;
    end

    assign danger_en1   = slot_en[0];
    assign danger_en2   = slot_en[1];
    assign danger_en3   = slot_en[2];
    assign danger_pos1  = slot_pos[0];
    assign danger_pos2  = slot_pos[1];
    assign danger_pos3  = slot_pos[2];
    assign danger_type1 = slot_type[0];
    assign danger_type2 = slot_type[1];
    assign danger_type3 = slot_type[2];

endmodule

// File: tb/tb_danger_scheduler.sv
// Self-checking bench: directed table, hand-written corner sequences and a long
// randomized run, all compared every cycle against a behavioural scheduler model.
module tb_danger_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [1:0] game_state;
    logic [3:0] speed;
    logic [9:0] danger_pos1, danger_pos2, danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic       danger_en1, danger_en2, danger_en3;

    always #5 clk = ~clk;

    danger_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_state   (game_state),
        .speed        (speed),
        .danger_pos1  (danger_pos1),
        .danger_pos2  (danger_pos2),
        .danger_pos3  (danger_pos3),
        .danger_type1 (danger_type1),
        .danger_type2 (danger_type2),
        .danger_type3 (danger_type3),
        .danger_en1   (danger_en1),
        .danger_en2   (danger_en2),
        .danger_en3   (danger_en3)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_en[3];
    int          m_pos[3];
    int          m_type[3];
    int          m_dist, m_gap;
    logic [15:0] m_lfsr;
    int          tmap[8] = '{0, 1, 2, 3, 4, 2, 4, 3};
    int          blocked_events = 0;
    int          reuse_events = 0;

    function automatic void model_step(input bit r, input logic [1:0] g, input bit t, input int sp);
        bit freed_now;
        int f;
        if (!r) begin
            for (int i = 0; i < 3; i++) begin m_en[i] = 0; m_pos[i] = 0; m_type[i] = 5; end
            m_dist = 0;
            m_gap  = 160;
            m_lfsr = 16'hACE1;
            return;
        end
        if (g == 2'd3) begin
            for (int i = 0; i < 3; i++) begin m_en[i] = 0; m_pos[i] = 0; m_type[i] = 5; end
            m_dist = 0;
            m_gap  = 160;
        end else if (g == 2'd1 && t) begin
            freed_now = 0;
            for (int i = 0; i < 3; i++) begin
                if (m_en[i]) begin
                    if (m_pos[i] > sp) m_pos[i] -= sp;
                    else begin m_en[i] = 0; m_pos[i] = 0; m_type[i] = 5; freed_now = 1; end
                end
            end
            m_dist = (m_dist + sp > 1023) ? 1023 : m_dist + sp;
            if (m_dist >= m_gap) begin
                f = -1;
                for (int i = 2; i >= 0; i--) if (!m_en[i]) f = i;
                if (f >= 0) begin
                    if (freed_now) reuse_events++;
                    m_en[f]   = 1;
                    m_pos[f]  = 700;
                    m_type[f] = tmap[m_lfsr % 8];
                    m_dist    = 0;
                    m_gap     = 160 + ((m_lfsr >> 4) % 128);
                end else begin
                    blocked_events++;
                end
            end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        bit ok;
        ok = (danger_en1 === m_en[0]) && (danger_en2 === m_en[1]) && (danger_en3 === m_en[2]) &&
             (int'(danger_pos1) === m_pos[0]) && (int'(danger_pos2) === m_pos[1]) &&
             (int'(danger_pos3) === m_pos[2]) &&
             (int'(danger_type1) === m_type[0]) && (int'(danger_type2) === m_type[1]) &&
             (int'(danger_type3) === m_type[2]) && (dut.u_lfsr.state === m_lfsr);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cycle_cmp at %0t actual en=%b%b%b pos=%0d,%0d,%0d type=%0d,%0d,%0d lfsr=%h required en=%b%b%b pos=%0d,%0d,%0d type=%0d,%0d,%0d lfsr=%h",
                     $time, danger_en3, danger_en2, danger_en1, danger_pos1, danger_pos2, danger_pos3,
                     danger_type1, danger_type2, danger_type3, dut.u_lfsr.state,
                     m_en[2], m_en[1], m_en[0], m_pos[0], m_pos[1], m_pos[2],
                     m_type[0], m_type[1], m_type[2], m_lfsr);
        end
    endtask

    // Drive one clock cycle of inputs, advance the model on the edge, compare #1 later.
    task automatic cycle(input bit r, input logic [1:0] g, input bit t, input int sp);
        rst        = r;
        game_state = g;
        frame_tick = t;
        speed      = 4'(sp);
        @(posedge clk);
        model_step(r, g, t, sp);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [1:0] gs;
        int         spd;
        int         n_ticks;
        logic [2:0] exp_en;    // {en3, en2, en1}
        int         exp_pos1;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        int         exp_type;
    } map_vec_t;

    vec_t     tbl[11];
    map_vec_t mtbl[8];

    initial begin
        tbl[0]  = '{2'd0, 4,  5,  3'b000, 0};    // INIT ignores ticks
        tbl[1]  = '{2'd1, 4,  39, 3'b000, 0};    // dist reaches 156
        tbl[2]  = '{2'd1, 4,  1,  3'b001, 700};  // dist 160 -> slot1 spawns
        tbl[3]  = '{2'd1, 4,  10, 3'b001, 660};
        tbl[4]  = '{2'd2, 4,  10, 3'b001, 660};  // END freezes
        tbl[5]  = '{2'd0, 4,  5,  3'b001, 660};  // INIT holds
        tbl[6]  = '{2'd3, 4,  1,  3'b000, 0};    // RESET clears
        tbl[7]  = '{2'd1, 0,  5,  3'b000, 0};    // speed 0: no progress
        tbl[8]  = '{2'd1, 15, 10, 3'b000, 0};    // dist 150
        tbl[9]  = '{2'd1, 15, 1,  3'b001, 700};  // dist 165 -> spawn
        tbl[10] = '{2'd1, 15, 5,  3'b001, 625};
        for (int c = 0; c < 8; c++) mtbl[c] = '{3'(c), (c < 5) ? c : ((c == 5) ? 2 : ((c == 6) ? 4 : 3))};

        rst = 1'b0; frame_tick = 1'b0; game_state = 2'd0; speed = 4'd0;
        cycle(0, 2'd0, 0, 0);
        cycle(0, 2'd0, 1, 4);
        check("reset_en1", int'(danger_en1), 0);
        check("reset_type1", int'(danger_type1), 5);

        for (int s = 0; s < 11; s++) begin
            for (int k = 0; k < tbl[s].n_ticks; k++) begin
                cycle(1, tbl[s].gs, 1, tbl[s].spd);
                cycle(1, tbl[s].gs, 0, tbl[s].spd);
            end
            check($sformatf("tbl%0d_en", s), int'({danger_en3, danger_en2, danger_en1}), int'(tbl[s].exp_en));
            check($sformatf("tbl%0d_pos1", s), int'(danger_pos1), tbl[s].exp_pos1);
        end

        for (int c = 0; c < 8; c++)
            check($sformatf("type_map%0d", c), int'(danger_scheduler_pkg::map_type(mtbl[c].code)), mtbl[c].exp_type);

        // Reset asserted mid-RUN together with a tick
        for (int k = 0; k < 3; k++) cycle(1, 2'd1, 1, 4);
        cycle(0, 2'd1, 1, 4);
        check("midrun_rst_en", int'({danger_en3, danger_en2, danger_en1}), 0);
        check("midrun_rst_pos1", int'(danger_pos1), 0);
        check("midrun_rst_type1", int'(danger_type1), 5);
        check("midrun_rst_lfsr", int'(dut.u_lfsr.state), 'hACE1);

        // First RUN tick straight after release
        cycle(1, 2'd1, 1, 15);
        check("post_rst_en1", int'(danger_en1), 0);

        // Slow scroll fills all three slots, exercising blocked spawns and same-tick reuse
        for (int k = 0; k < 3000; k++) cycle(1, 2'd1, 1, 1);

        // Randomized mix of states, ticks, speeds and occasional reset
        for (int k = 0; k < 4000; k++) begin
            int  p;
            logic [1:0] g;
            p = $urandom_range(99);
            g = (p < 70) ? 2'd1 : (p < 82) ? 2'd2 : (p < 94) ? 2'd0 : 2'd3;
            cycle(($urandom_range(199) == 0) ? 1'b0 : 1'b1, g, 1'($urandom_range(1)), $urandom_range(15));
        end

        $display("coverage: blocked=%0d same_tick_reuse=%0d", blocked_events, reuse_events);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
